// File: rtl/square_motion.sv
// Motion stage for the dodge game: owns the 16 obstacle squares and the player
// square, steps them once per refresh_tick and publishes them on a packed bus.
`timescale 1ns/1ps
module square_motion #(
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int SQUARE_SIZE  = 30,
  parameter int OBST_SPEED   = 2,
  parameter int PLAYER_SPEED = 3,
  parameter int PARK_COORD   = 1000,
  parameter int PLAYER_X0    = 305,
  parameter int PLAYER_Y0    = 225,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refresh_tick,
  input  logic         btn_start,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         status,
  input  logic [5:0]   num_squares,
  output logic [659:0] position,
  output logic [1:0]   game_state,
  output logic [4:0]   active_count
);

  localparam logic [9:0]  XLIM  = 10'(H_MAX - SQUARE_SIZE);
  localparam logic [9:0]  YLIM  = 10'(V_MAX - SQUARE_SIZE);
  localparam logic [10:0] OSTEP = 11'(OBST_SPEED);
  localparam logic [10:0] PSTEP = 11'(PLAYER_SPEED);
  localparam logic [9:0]  PARK  = 10'(PARK_COORD);
  localparam logic [9:0]  PX0   = 10'(PLAYER_X0);
  localparam logic [9:0]  PY0   = 10'(PLAYER_Y0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_lfsr;
  logic [9:0]  r_x  [16];
  logic [9:0]  r_y  [16];
  logic        r_dx [16];
  logic        r_dy [16];
  logic [9:0]  r_px;
  logic [9:0]  r_py;

  logic [10:0] w_xs [16];
  logic [10:0] w_ys [16];
  logic [9:0]  w_px_nxt;
  logic [9:0]  w_py_nxt;
  logic [4:0]  w_target;
  logic        w_fb;

  // Obstacle axis step; result is {new_dir, new_coord}. Sums are 11 bits so they cannot wrap.
  function automatic logic [10:0] obst_step(input logic [9:0] c, input logic d,
                                            input logic [9:0] lim);
    logic [10:0] sum;
    logic [10:0] res;
    sum = {1'b0, c} + OSTEP;
    if (d) begin
      if (sum > {1'b0, lim}) res = {1'b0, lim};
      else                   res = {1'b1, sum[9:0]};
    end else begin
      if ({1'b0, c} < OSTEP) res = {1'b1, 10'd0};
      else                   res = {1'b0, c - OSTEP[9:0]};
    end
    return res;
  endfunction

  function automatic logic [9:0] player_step(input logic [9:0] c, input logic dec,
                                             input logic inc, input logic [9:0] lim);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = {1'b0, c} + PSTEP;
    res = c;
    if (dec && !inc) res = ({1'b0, c} < PSTEP) ? 10'd0 : c - PSTEP[9:0];
    if (inc && !dec) res = (sum > {1'b0, lim}) ? lim : sum[9:0];
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_xs[i] = obst_step(r_x[i], r_dx[i], XLIM);
      w_ys[i] = obst_step(r_y[i], r_dy[i], YLIM);
    end
    w_px_nxt = player_step(r_px, btn_left, btn_right, XLIM);
    w_py_nxt = player_step(r_py, btn_up, btn_down, YLIM);
    w_target = (num_squares > 6'd16) ? 5'd16 : num_squares[4:0];
    w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_lfsr  <= LFSR_SEED;
      r_px    <= PX0;
      r_py    <= PY0;
      for (int i = 0; i < 16; i++) begin
        r_x[i]  <= PARK;
        r_y[i]  <= PARK;
        r_dx[i] <= 1'b0;
        r_dy[i] <= 1'b0;
      end
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_state)
        ST_IDLE: if (btn_start) r_state <= ST_RUN;
        ST_RUN: begin
          if (refresh_tick) begin
            if (!status) begin
              r_state <= ST_OVER;
            end else begin
              r_px <= w_px_nxt;
              r_py <= w_py_nxt;
              for (int i = 0; i < 16; i++) begin
                if (5'(i) < r_cnt) begin
                  r_x[i]  <= w_xs[i][9:0];
                  r_dx[i] <= w_xs[i][10];
                  r_y[i]  <= w_ys[i][9:0];
                  r_dy[i] <= w_ys[i][10];
                end
              end
              // The spawned slot index is >= r_cnt, so it never collides with a move above.
              if (r_cnt < w_target) begin
                r_x[r_cnt[3:0]]  <= {1'b0, r_lfsr[8:0]};
                r_y[r_cnt[3:0]]  <= 10'd0;
                r_dx[r_cnt[3:0]] <= r_lfsr[9];
                r_dy[r_cnt[3:0]] <= 1'b1;
                r_cnt            <= r_cnt + 5'd1;
              end
            end
          end
        end
        ST_OVER: begin
          if (btn_start) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_px    <= PX0;
            r_py    <= PY0;
            for (int i = 0; i < 16; i++) begin
              r_x[i]  <= PARK;
              r_y[i]  <= PARK;
              r_dx[i] <= 1'b0;
              r_dy[i] <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pure wiring from registers: the bus is registered with no logic after the flops.
  always_comb begin
    position = '0;
    for (int i = 0; i < 16; i++) begin
      position[40*i +: 10]    = r_x[i];
      position[40*i+10 +: 10] = r_y[i];
      position[40*i+20]       = r_dx[i];
      position[40*i+21]       = r_dy[i];
    end
    position[649:640] = r_px;
    position[659:650] = r_py;
  end

  assign game_state   = r_state;
  assign active_count = r_cnt;

endmodule

// File: tb/tb_square_motion.sv
// Directed bench for square_motion: hand-computed player/limit values plus a
// small behavioural model of obstacle motion, compared after every refresh tick.
`timescale 1ns/1ps
module tb_square_motion;

  logic         clk = 1'b0;
  logic         reset;
  logic         refresh_tick;
  logic         btn_start, btn_up, btn_down, btn_left, btn_right;
  logic         status;
  logic [5:0]   num_squares;
  logic [659:0] position;
  logic [1:0]   game_state;
  logic [4:0]   active_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  square_motion dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .btn_start    (btn_start),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .status       (status),
    .num_squares  (num_squares),
    .position     (position),
    .game_state   (game_state),
    .active_count (active_count)
  );

  // Expected state
  logic [15:0] m_lfsr;
  int          ex [16];
  int          ey [16];
  bit          edx [16];
  bit          edy [16];
  int          epx, epy, ecnt;
  logic [1:0]  est;

  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [659:0] got, input logic [659:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ex[i] = 1000; ey[i] = 1000; edx[i] = 0; edy[i] = 0;
    end
    epx = 305; epy = 225; ecnt = 0; est = 2'd0;
  endtask

  function automatic logic [659:0] exp_bus();
    logic [659:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      b[40*i +: 10]    = 10'(ex[i]);
      b[40*i+10 +: 10] = 10'(ey[i]);
      b[40*i+20]       = edx[i];
      b[40*i+21]       = edy[i];
    end
    b[649:640] = 10'(epx);
    b[659:650] = 10'(epy);
    return b;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pos"},   position,     exp_bus());
    check({tag, ".state"}, 660'(game_state),   660'(est));
    check({tag, ".count"}, 660'(active_count), 660'(ecnt));
  endtask

  // Called at posedge+1; applies one refresh tick and checks the result.
  task automatic tick(input string tag);
    logic [15:0] l;
    int tgt;
    l = m_lfsr;
    refresh_tick = 1'b1;
    @(posedge clk);
    #1 refresh_tick = 1'b0;
    if (est == 2'd1) begin
      if (!status) begin
        est = 2'd2;
      end else begin
        if (btn_left && !btn_right) epx = (epx < 3) ? 0 : epx - 3;
        if (btn_right && !btn_left) epx = (epx + 3 > 610) ? 610 : epx + 3;
        if (btn_up && !btn_down)    epy = (epy < 3) ? 0 : epy - 3;
        if (btn_down && !btn_up)    epy = (epy + 3 > 450) ? 450 : epy + 3;
        for (int i = 0; i < ecnt; i++) begin
          if (edx[i]) begin
            if (ex[i] + 2 > 610) begin ex[i] = 610; edx[i] = 0; end
            else ex[i] = ex[i] + 2;
          end else begin
            if (ex[i] < 2) begin ex[i] = 0; edx[i] = 1; end
            else ex[i] = ex[i] - 2;
          end
          if (edy[i]) begin
            if (ey[i] + 2 > 450) begin ey[i] = 450; edy[i] = 0; end
            else ey[i] = ey[i] + 2;
          end else begin
            if (ey[i] < 2) begin ey[i] = 0; edy[i] = 1; end
            else ey[i] = ey[i] - 2;
          end
        end
        tgt = (num_squares > 16) ? 16 : int'(num_squares);
        if (ecnt < tgt) begin
          ex[ecnt] = int'(l[8:0]); ey[ecnt] = 0; edx[ecnt] = l[9]; edy[ecnt] = 1;
          ecnt++;
        end
      end
    end
    check_all(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    @(posedge clk);
    #1 btn_start = 1'b0;
    if (est == 2'd0) est = 2'd1;
    else if (est == 2'd2) model_reset();
  endtask

  initial begin
    reset = 1'b1; refresh_tick = 1'b0; btn_start = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    status = 1'b1; num_squares = 6'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      check("rst_x",  660'(position[40*i +: 10]),    660'(10'd1000));
      check("rst_y",  660'(position[40*i+10 +: 10]), 660'(10'd1000));
      check("rst_hi", 660'(position[40*i+20 +: 20]), 660'(20'd0));
    end
    check("rst_px", 660'(position[649:640]), 660'(10'd305));
    check("rst_py", 660'(position[659:650]), 660'(10'd225));
    check("rst_state", 660'(game_state), 660'(2'd0));
    check("rst_count", 660'(active_count), 660'(5'd0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ticks in IDLE must be ignored
    tick("idle_tick");
    num_squares = 6'd3;
    press_start();
    check("start_state", 660'(game_state), 660'(2'd1));

    tick("spawn1");
    check("slot0_y_t1", 660'(position[19:10]), 660'(10'd0));
    check("cnt_t1", 660'(active_count), 660'(5'd1));
    tick("spawn2");
    check("slot0_y_t2", 660'(position[19:10]), 660'(10'd2));
    check("cnt_t2", 660'(active_count), 660'(5'd2));
    tick("spawn3");
    check("cnt_t3", 660'(active_count), 660'(5'd3));
    ticks(2, "spawn_hold");
    check("cnt_t5", 660'(active_count), 660'(5'd3));

    // Shrinking the request never despawns; start is ignored while running
    num_squares = 6'd1;
    btn_start = 1'b1;
    tick("shrink");
    btn_start = 1'b0;
    check("shrink_cnt", 660'(active_count), 660'(5'd3));
    check("run_start_ign", 660'(game_state), 660'(2'd1));

    btn_left = 1'b1;
    tick("left1");
    check("left_x_302", 660'(position[649:640]), 660'(10'd302));
    ticks(109, "left");
    check("left_clamp_0", 660'(position[649:640]), 660'(10'd0));
    btn_left = 1'b0;

    btn_up = 1'b1; btn_down = 1'b1;
    tick("updown");
    check("updown_y", 660'(position[659:650]), 660'(10'd225));
    btn_up = 1'b0; btn_down = 1'b0;

    btn_right = 1'b1;
    ticks(210, "right");
    check("right_clamp_610", 660'(position[649:640]), 660'(10'd610));
    btn_right = 1'b0;
    btn_down = 1'b1;
    ticks(80, "down");
    check("down_clamp_450", 660'(position[659:650]), 660'(10'd450));
    btn_down = 1'b0;
    btn_up = 1'b1;
    ticks(200, "up");
    check("up_clamp_0", 660'(position[659:650]), 660'(10'd0));
    btn_up = 1'b0;

    // Collision freezes play
    status = 1'b0;
    btn_left = 1'b1;
    tick("collide");
    check("over_state", 660'(game_state), 660'(2'd2));
    status = 1'b1;
    ticks(3, "frozen");
    btn_left = 1'b0;
    press_start();
    check_all("restart");
    check("restart_state", 660'(game_state), 660'(2'd0));
    check("restart_px", 660'(position[649:640]), 660'(10'd305));

    num_squares = 6'd40;
    press_start();
    ticks(20, "spawn40");
    check("sat_16", 660'(active_count), 660'(5'd16));

    // Asynchronous reset in the middle of a clock period
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_state", 660'(game_state), 660'(2'd0));
    @(posedge clk);
    #1 reset = 1'b0;
    tick("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
